// File: rtl/regfile_read_arbiter_if.sv
// Read-port bundle between the requesters/register-file MUX and regfile_read_arbiter.
// The arbiter uses the slave modport. The environment uses the master modport.
interface regfile_read_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [5*NREQ-1:0] addr;
    logic [NREQ-1:0]   lock;
    logic [NREQ-1:0]   gnt;
    logic [4:0]        S;
    logic [31:0]       P;
    logic [31:0]       rdata;
    logic [NREQ-1:0]   rvalid;
    logic              busy;

    modport master (
        output req, addr, lock, P,
        input  gnt, S, rdata, rvalid, busy
    );

    modport slave (
        input  req, addr, lock, P,
        output gnt, S, rdata, rvalid, busy
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the register file's single read port. It supports a per-requester lock.
// Optional macro REGFILE_R0_ZERO_EN forces reads of register 0 to return zero.
module regfile_read_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_LOCK = 8
) (
    input logic                  clk,
    input logic                  reset,
    regfile_read_arbiter_if.slave bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [7:0]      lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [4:0]      s_q, s_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [4:0]      addr_a [NREQ];
    logic [IDXW-1:0] next_ptr;
    logic [IDXW-1:0] scan_ptr;
    logic [IDXW-1:0] win;
    logic            win_found;
    logic            other_req;
    logic            at_max;
    logic            keep;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = bus.addr[5*i +: 5];
        end
    end

    // The pointer after the current owner is also the re-scan start when the owner is released.
    always_comb begin
        int nxt;
        nxt      = int'(owner_q) + 1;
        if (nxt >= NREQ) nxt = 0;
        next_ptr = IDXW'(nxt);
        scan_ptr = (state_q == GRANT) ? next_ptr : rr_ptr_q;
    end

    always_comb begin : rr_scan
        int idx;
        win       = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(scan_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && bus.req[IDXW'(idx)]) begin
                win_found = 1'b1;
                win       = IDXW'(idx);
            end
        end
    end

    assign other_req = |(bus.req & ~gnt_q);
    assign at_max    = (lock_cnt_q == 8'(MAX_LOCK));
    assign keep      = bus.req[owner_q] & bus.lock[owner_q] & ~(other_req & at_max);

    // NOTE: each variable gets a default value at the top of the block. This keeps the block free of inferred latches.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = gnt_q;
        s_d        = s_q;
        rdata_d    = rdata_q;
        rvalid_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d      = NREQ'(1) << win;
                    s_d        = addr_a[win];
                    owner_d    = win;
                    lock_cnt_d = 8'd1;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // The read of register S issued in this cycle always completes.
`ifdef REGFILE_R0_ZERO_EN
                rdata_d  = (s_q == 5'd0) ? 32'h0 : bus.P;
`else
                rdata_d  = bus.P;
`endif
                rvalid_d = gnt_q;
                if (keep) begin
                    s_d = addr_a[owner_q];
                    if (!at_max) lock_cnt_d = lock_cnt_q + 8'd1;
                end else begin
                    rr_ptr_d = next_ptr;
                    if (win_found) begin
                        gnt_d      = NREQ'(1) << win;
                        s_d        = addr_a[win];
                        owner_d    = win;
                        lock_cnt_d = 8'd1;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. This makes every register sample its old value at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            s_q        <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            s_q        <= s_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.S      = s_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = (state_q == GRANT);
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter (NREQ=4, MAX_LOCK=3).
// The register-file MUX model returns R_i = i+1.
module tb_regfile_read_arbiter;
    localparam int NREQ     = 4;
    localparam int MAX_LOCK = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    regfile_read_arbiter_if #(.NREQ(NREQ)) bus ();

    regfile_read_arbiter #(
        .NREQ    (NREQ),
        .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.P = {27'd0, bus.S} + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        bus.addr[5*i +: 5] = a;
    endtask

    initial begin
        logic [3:0]  exp_gnt [6];
        logic [3:0]  exp_rv  [6];
        logic [31:0] exp_rd  [6];
        checks = 0;
        errors = 0;
        exp_gnt = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
        exp_rv  = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        exp_rd  = '{32'd0, 32'd2, 32'd3, 32'd4, 32'd5, 32'd2};

        reset    = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        bus.addr = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_gnt",    32'(bus.gnt),    32'h0);
        check("rst_S",      32'(bus.S),      32'h0);
        check("rst_rdata",  bus.rdata,       32'h0);
        check("rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("rst_busy",   32'(bus.busy),   32'h0);

        // Single request from requester 0 for addr 5. This leaves rr_ptr at 1.
        bus.req = 4'b0001;
        set_addr(0, 5'd5);
        step();
        check("single_gnt",  32'(bus.gnt),  32'h1);
        check("single_S",    32'(bus.S),    32'd5);
        check("single_busy", 32'(bus.busy), 32'h1);
        bus.req = '0;
        step();
        check("single_rdata",  bus.rdata,       32'd6);
        check("single_rvalid", 32'(bus.rvalid), 32'h1);
        check("single_gnt0",   32'(bus.gnt),    32'h0);
        check("single_idle",   32'(bus.busy),   32'h0);
        step();
        check("single_rv_off", 32'(bus.rvalid), 32'h0);

        // Requester 1 wins from rr_ptr=1 and holds a lock on addr 31.
        // Reset is then asserted in the middle of a cycle.
        bus.req  = 4'b0010;
        bus.lock = 4'b0010;
        set_addr(1, 5'd31);
        step();
        check("mid_gnt",    32'(bus.gnt), 32'h2);
        check("mid_S",      32'(bus.S),   32'd31);
        step();
        check("mid_rdata",  bus.rdata,       32'd32);
        check("mid_rvalid", 32'(bus.rvalid), 32'h2);
        #2;
        reset    = 1'b1;
        bus.req  = '0;
        bus.lock = '0;
        #1;
        check("async_gnt",    32'(bus.gnt),    32'h0);
        check("async_S",      32'(bus.S),      32'h0);
        check("async_rdata",  bus.rdata,       32'h0);
        check("async_rvalid", 32'(bus.rvalid), 32'h0);
        check("async_busy",   32'(bus.busy),   32'h0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_rvalid", 32'(bus.rvalid), 32'h0);
        check("post_rst_gnt",    32'(bus.gnt),    32'h0);

        // Contention with no lock. Grant 0 first shows that rr_ptr returned to 0.
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("rot_gnt%0d", k), 32'(bus.gnt), 32'(exp_gnt[k]));
            check($sformatf("rot_rv%0d", k),  32'(bus.rvalid), 32'(exp_rv[k]));
            if (k > 0) check($sformatf("rot_rd%0d", k), bus.rdata, exp_rd[k]);
        end
        bus.req = '0;
        step();
        check("rot_tail_rd", bus.rdata,       32'd3);
        check("rot_tail_rv", 32'(bus.rvalid), 32'h2);
        check("rot_idle",    32'(bus.busy),   32'h0);
        step();

        // Locked requester 0 with requester 1 pending. rr_ptr=2 wraps to 0.
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        set_addr(0, 5'd10);
        set_addr(1, 5'd20);
        step();
        check("lk_gnt0", 32'(bus.gnt), 32'h1);
        set_addr(0, 5'd11);
        step();
        check("lk_rd1",  bus.rdata,       32'h0B);
        check("lk_rv1",  32'(bus.rvalid), 32'h1);
        check("lk_gnt1", 32'(bus.gnt),    32'h1);
        set_addr(0, 5'd12);
        step();
        check("lk_rd2",  bus.rdata,    32'h0C);
        check("lk_gnt2", 32'(bus.gnt), 32'h1);
        set_addr(0, 5'd13);
        step();
        check("lk_rd3",     bus.rdata,       32'h0D);
        check("lk_rv3",     32'(bus.rvalid), 32'h1);
        check("lk_release", 32'(bus.gnt),    32'h2);
        check("lk_S1",      32'(bus.S),      32'd20);
        bus.req  = '0;
        bus.lock = '0;
        step();
        check("lk_rd_r1", bus.rdata,       32'd21);
        check("lk_rv_r1", 32'(bus.rvalid), 32'h2);
        step();

        // A lock with no competitor is never released, even past MAX_LOCK.
        bus.req  = 4'b0001;
        bus.lock = 4'b0001;
        set_addr(0, 5'd7);
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("unl_rv%0d", k),  32'(bus.rvalid), 32'h1);
            check($sformatf("unl_gnt%0d", k), 32'(bus.gnt),    32'h1);
        end
        check("unl_rd", bus.rdata, 32'd8);
        // A competitor that arrives once the count is saturated forces release at the next edge.
        bus.req = 4'b0011;
        set_addr(1, 5'd2);
        step();
        check("sat_rv",  32'(bus.rvalid), 32'h1);
        check("sat_gnt", 32'(bus.gnt),    32'h2);
        bus.req  = '0;
        bus.lock = '0;
        step();
        check("sat_rd", bus.rdata, 32'd3);
        step();

        // Reading register 0.
        bus.req = 4'b0001;
        set_addr(0, 5'd0);
        step();
        check("r0_S", 32'(bus.S), 32'd0);
        bus.req = '0;
        step();
        check("r0_rv", 32'(bus.rvalid), 32'h1);
`ifdef REGFILE_R0_ZERO_EN
        check("r0_rdata", bus.rdata, 32'h0);
`else
        check("r0_rdata", bus.rdata, 32'h1);
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
